// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding.
package uart_pkg;

   localparam int unsigned DATA_BITS  = 16;
   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W      = $clog2(DATA_BITS);
   localparam int unsigned MID_TICK   = OVERSAMPLE / 2 - 1;
   localparam int unsigned LAST_TICK  = OVERSAMPLE - 1;
   localparam int unsigned LAST_BIT   = DATA_BITS - 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      STOP    = 3'd3,
      RECOVER = 3'd4
   } rx_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchroniser for an asynchronous level; idles high, holds when disabled.
module sync_ff #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift the line through the chain; reset to the idle (high) level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '1;
      end else if (enable) begin
         sync_q <= STAGES'({sync_q, d_i});
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: start validation, LSB-first data, stop check.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 rx,
   input  logic                 rx_tick,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_done,
   output logic                 frame_err
);

   logic                 rx_s;
   rx_state_e            state_q,  state_d;
   logic [TICK_W-1:0]    tick_q,   tick_d;
   logic [BIT_W-1:0]     bit_q,    bit_d;
   logic [DATA_BITS-1:0] shreg_q,  shreg_d;
   logic [DATA_BITS-1:0] data_q,   data_d;
   logic                 done_q,   done_d;
   logic                 err_q,    err_d;

   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .d_i    (rx),
      .q_o    (rx_s)
   );

   // State, counters and outputs; everything holds while disabled, strobes drop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else if (enable) begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end else begin
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end
   end

   // Next-state: frame sequencing driven by the oversampling tick.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               tick_d  = '0;
            end
         end

         START: begin
            if (rx_tick) begin
               if (tick_q == TICK_W'(MID_TICK)) begin
                  if (!rx_s) begin
                     state_d = DATA;
                     tick_d  = '0;
                     bit_d   = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end
         end

         DATA: begin
            if (rx_tick) begin
               if (tick_q == TICK_W'(LAST_TICK)) begin
                  shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                  tick_d  = '0;
                  if (bit_q == BIT_W'(LAST_BIT)) begin
                     state_d = STOP;
                  end else begin
                     bit_d = bit_q + BIT_W'(1);
                  end
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end
         end

         STOP: begin
            if (rx_tick) begin
               if (tick_q == TICK_W'(LAST_TICK)) begin
                  if (rx_s) begin
                     data_d  = shreg_q;
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end else begin
                     err_d   = 1'b1;
                     state_d = RECOVER;
                  end
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end
         end

         // Hold off until the line returns high so a break is not decoded as frames.
         RECOVER: begin
            if (rx_s) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign rx_data   = data_q;
   assign rx_done   = done_q;
   assign frame_err = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with a behavioural serialiser and frame model.
module tb_uart_rx;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        rx;
   logic        rx_tick = 1'b0;
   logic [15:0] rx_data;
   logic        rx_done;
   logic        frame_err;

   int          checks = 0;
   int          failures = 0;

   // Monitor records
   int          n_done = 0;
   int          n_err = 0;
   int          n_both = 0;
   int          n_dis = 0;
   logic [15:0] obs_q[$];

   // Model: last word whose frame had a good stop bit
   logic [15:0] last_good;

   int          div = 0;

   always #5 clk = ~clk;

   uart_rx #(
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .rx        (rx),
      .rx_tick   (rx_tick),
      .rx_data   (rx_data),
      .rx_done   (rx_done),
      .frame_err (frame_err)
   );

   // Tick generator: one pulse every 4 clk, frozen while enable is low
   always @(negedge clk) begin
      if (enable === 1'b1) begin
         div     = (div + 1) % 4;
         rx_tick = (div == 0);
      end
   end

   // Strobe monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (rx_done === 1'b1) begin
         n_done++;
         obs_q.push_back(rx_data);
      end
      if (frame_err === 1'b1) n_err++;
      if (rx_done === 1'b1 && frame_err === 1'b1) n_both++;
      if (enable !== 1'b1 && (rx_done === 1'b1 || frame_err === 1'b1)) n_dis++;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         do @(posedge clk); while (rx_tick !== 1'b1);
      end
      #1;
   endtask

   // Serialise one frame; optionally freeze during pause_bit or stop at abort_bit
   task automatic send_frame(input logic [15:0] w, input logic stop,
                             input int pause_bit, input int abort_bit);
      rx = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 16; i++) begin
         rx = w[i];
         if (i == abort_bit) begin
            wait_ticks(8);
            return;
         end
         if (i == pause_bit) begin
            wait_ticks(8);
            enable = 1'b0;
            repeat (100) @(posedge clk);
            #1 enable = 1'b1;
            wait_ticks(8);
         end else begin
            wait_ticks(16);
         end
      end
      rx = stop;
      wait_ticks(16);
      if (stop) last_good = w;
   endtask

   task automatic test_reset;
      reset  = 1'b1;
      enable = 1'b1;
      rx     = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      last_good = 16'h0000;
      checks++;
      if (rx_data !== 16'h0000) begin
         failures++;
         $display("FAIL reset_rx_data: got %h want 0000", rx_data);
      end
      checks++;
      if (rx_done !== 1'b0) begin
         failures++;
         $display("FAIL reset_rx_done: got %b want 0", rx_done);
      end
      checks++;
      if (frame_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_frame_err: got %b want 0", frame_err);
      end
      reset = 1'b0;
      wait_ticks(20);
      checks++;
      if (n_done != 0 || n_err != 0) begin
         failures++;
         $display("FAIL reset_idle_strobes: done=%0d err=%0d want 0 0", n_done, n_err);
      end
   endtask

   task automatic test_loopback;
      logic [15:0] words[$];
      logic [15:0] got;
      int d0, e0, q0;
      d0 = n_done; e0 = n_err; q0 = obs_q.size();
      words = '{16'hA5C3, 16'h0000, 16'hFFFF};
      for (int i = 0; i < 3; i++) words.push_back(16'($urandom));
      for (int i = 0; i < words.size(); i++) begin
         if (i >= 3) begin
            rx = 1'b1;
            wait_ticks($urandom_range(0, 24));
         end
         send_frame(words[i], 1'b1, -1, -1);
      end
      rx = 1'b1;
      wait_ticks(24);
      checks++;
      if (n_done - d0 != words.size()) begin
         failures++;
         $display("FAIL loopback_done_count: got %0d want %0d", n_done - d0, words.size());
      end
      for (int i = 0; i < words.size(); i++) begin
         got = (q0 + i < obs_q.size()) ? obs_q[q0 + i] : 16'hxxxx;
         checks++;
         if (got !== words[i]) begin
            failures++;
            $display("FAIL loopback_word%0d: got %h want %h", i, got, words[i]);
         end
      end
      checks++;
      if (n_err - e0 != 0) begin
         failures++;
         $display("FAIL loopback_frame_err: got %0d pulses want 0", n_err - e0);
      end
      checks++;
      if (rx_data !== last_good) begin
         failures++;
         $display("FAIL loopback_rx_data_hold: got %h want %h", rx_data, last_good);
      end
   endtask

   task automatic test_glitch;
      int d0, e0, q0, len;
      d0 = n_done; e0 = n_err; q0 = obs_q.size();
      for (int g = 0; g < 2; g++) begin
         len = (g == 0) ? 4 : int'($urandom_range(1, 6));
         rx = 1'b0;
         wait_ticks(len);
         rx = 1'b1;
         wait_ticks(24);
      end
      checks++;
      if (n_done != d0 || n_err != e0) begin
         failures++;
         $display("FAIL glitch_no_strobe: done=%0d err=%0d want 0 0", n_done - d0, n_err - e0);
      end
      send_frame(16'h1234, 1'b1, -1, -1);
      wait_ticks(24);
      checks++;
      if (n_done - d0 != 1) begin
         failures++;
         $display("FAIL glitch_next_count: got %0d want 1", n_done - d0);
      end
      checks++;
      if (q0 >= obs_q.size() || obs_q[q0] !== 16'h1234) begin
         failures++;
         $display("FAIL glitch_next_word: got %h want 1234", rx_data);
      end
   endtask

   task automatic test_frame_err;
      logic [15:0] prev;
      int d0, e0, q0;
      d0 = n_done; e0 = n_err; q0 = obs_q.size();
      prev = last_good;
      send_frame(16'h00FF, 1'b0, -1, -1);
      wait_ticks(40);
      rx = 1'b1;
      wait_ticks(20);
      checks++;
      if (n_err - e0 != 1) begin
         failures++;
         $display("FAIL ferr_pulse_count: got %0d want 1", n_err - e0);
      end
      checks++;
      if (n_done != d0) begin
         failures++;
         $display("FAIL ferr_no_done: got %0d want 0", n_done - d0);
      end
      checks++;
      if (rx_data !== prev) begin
         failures++;
         $display("FAIL ferr_rx_data_hold: got %h want %h", rx_data, prev);
      end
      send_frame(16'hBEEF, 1'b1, -1, -1);
      wait_ticks(24);
      checks++;
      if (n_done - d0 != 1 || q0 >= obs_q.size() || obs_q[q0] !== 16'hBEEF) begin
         failures++;
         $display("FAIL ferr_recover_word: got %h count %0d want beef count 1",
                  rx_data, n_done - d0);
      end
      checks++;
      if (n_err - e0 != 1) begin
         failures++;
         $display("FAIL ferr_after_recover: got %0d pulses want 1", n_err - e0);
      end
   endtask

   task automatic test_enable;
      int d0, e0, q0;
      d0 = n_done; e0 = n_err; q0 = obs_q.size();
      rx = 1'b1;
      wait_ticks($urandom_range(2, 10));
      send_frame(16'h5A5A, 1'b1, 6, -1);
      wait_ticks(24);
      checks++;
      if (n_done - d0 != 1 || q0 >= obs_q.size() || obs_q[q0] !== 16'h5A5A) begin
         failures++;
         $display("FAIL enable_word: got %h count %0d want 5a5a count 1",
                  rx_data, n_done - d0);
      end
      checks++;
      if (n_dis != 0) begin
         failures++;
         $display("FAIL enable_strobe_while_low: got %0d want 0", n_dis);
      end
      checks++;
      if (n_err != e0) begin
         failures++;
         $display("FAIL enable_frame_err: got %0d want 0", n_err - e0);
      end
   endtask

   task automatic test_reset_mid;
      int d0, e0, q0;
      send_frame(16'($urandom), 1'b1, -1, 9);
      reset = 1'b1;
      #1;
      last_good = 16'h0000;
      checks++;
      if (rx_data !== 16'h0000) begin
         failures++;
         $display("FAIL midreset_rx_data: got %h want 0000", rx_data);
      end
      checks++;
      if (rx_done !== 1'b0 || frame_err !== 1'b0) begin
         failures++;
         $display("FAIL midreset_strobes: got %b%b want 00", rx_done, frame_err);
      end
      rx = 1'b1;
      repeat (5) @(posedge clk);
      #1 reset = 1'b0;
      d0 = n_done; e0 = n_err; q0 = obs_q.size();
      wait_ticks(32);
      checks++;
      if (n_done != d0 || n_err != e0) begin
         failures++;
         $display("FAIL midreset_idle: done=%0d err=%0d want 0 0", n_done - d0, n_err - e0);
      end
      send_frame(16'hC001, 1'b1, -1, -1);
      wait_ticks(24);
      checks++;
      if (n_done - d0 != 1 || q0 >= obs_q.size() || obs_q[q0] !== 16'hC001) begin
         failures++;
         $display("FAIL midreset_next_word: got %h count %0d want c001 count 1",
                  rx_data, n_done - d0);
      end
      checks++;
      if (rx_data !== last_good) begin
         failures++;
         $display("FAIL midreset_rx_data: got %h want %h", rx_data, last_good);
      end
   endtask

   task automatic test_exclusive;
      checks++;
      if (n_both != 0) begin
         failures++;
         $display("FAIL strobes_exclusive: got %0d overlaps want 0", n_both);
      end
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b1;
      rx     = 1'b1;
      test_reset();
      test_loopback();
      test_glitch();
      test_frame_err();
      test_enable();
      test_reset_mid();
      test_exclusive();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
